// File: rtl/sc_game_controller.sv
// Frogger game controller: sequences start, play, pause, death, house and
// level-up phases, and owns the life counter, level counter and house mask.
// Every output is decoded from registered state only (state, hold, lives).
module sc_game_controller #(
    parameter int LIVES_INIT  = 3,
    parameter int LIFE_W      = 3,
    parameter int LEVELS      = 4,
    parameter int LEVEL_W     = 3,
    parameter int HOUSES      = 5,
    parameter int HOUSE_IDX_W = 3,
    parameter int DEATH_HOLD  = 25000000,
    parameter int LEVEL_HOLD  = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic                   SC_GAMECTRL_CLOCK_50,
    input  logic                   SC_GAMECTRL_RESET_InHigh,
    input  logic                   SC_GAMECTRL_startButton_InLow,
    input  logic                   SC_GAMECTRL_pauseButton_InLow,
    input  logic                   SC_GAMECTRL_Collision_InLow,
    input  logic                   SC_GAMECTRL_HouseValid_InLow,
    input  logic [HOUSE_IDX_W-1:0] SC_GAMECTRL_HouseIndex_InBUS,
    output logic                   SC_GAMECTRL_StartGame_OutLow,
    output logic                   SC_GAMECTRL_LoadLevel_OutLow,
    output logic                   SC_GAMECTRL_LifeLost_OutLow,
    output logic                   SC_GAMECTRL_ResetFrog_OutLow,
    output logic                   SC_GAMECTRL_Freeze_OutLow,
    output logic                   SC_GAMECTRL_Win_OutHigh,
    output logic                   SC_GAMECTRL_Lose_OutHigh,
    output logic [LIFE_W-1:0]      SC_GAMECTRL_Lives_OutBUS,
    output logic [LEVEL_W-1:0]     SC_GAMECTRL_Level_OutBUS,
    output logic [HOUSES-1:0]      SC_GAMECTRL_HouseMask_OutBUS,
    output logic [3:0]             SC_GAMECTRL_State_OutBUS
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        PLAY     = 4'd2,
        PAUSE    = 4'd3,
        LOSELIFE = 4'd4,
        HOUSE    = 4'd5,
        LEVELUP  = 4'd6,
        GAMEOVER = 4'd7,
        WIN      = 4'd8
    } state_t;

    state_t               stateReg;
    logic [LIFE_W-1:0]    livesReg;
    logic [LEVEL_W-1:0]   levelReg;
    logic [HOUSES-1:0]    maskReg;
    logic [HOLD_W-1:0]    holdReg;
    logic                 startPrevReg;
    logic                 pausePrevReg;

    logic                 startPress;
    logic                 pausePress;
    logic [HOUSES-1:0]    houseOneHot;
    logic                 houseBad;

    // A press is the falling edge of the active-low button.
    assign startPress = startPrevReg & ~SC_GAMECTRL_startButton_InLow;
    assign pausePress = pausePrevReg & ~SC_GAMECTRL_pauseButton_InLow;

    // One-hot decode of the house index; an out-of-range index decodes to zero.
    generate
        for (genvar gi = 0; gi < HOUSES; gi++) begin : g_house_dec
            assign houseOneHot[gi] = (SC_GAMECTRL_HouseIndex_InBUS == HOUSE_IDX_W'(gi));
        end
    endgenerate

    // Invalid index or already-occupied house both cost a life.
    assign houseBad = ~(|houseOneHot) | (|(houseOneHot & maskReg));

    // Main game sequencer: state, counters, mask and button history.
    always_ff @(posedge SC_GAMECTRL_CLOCK_50) begin
        if (SC_GAMECTRL_RESET_InHigh) begin
            stateReg     <= IDLE;
            livesReg     <= LIFE_W'(LIVES_INIT);
            levelReg     <= '0;
            maskReg      <= '0;
            holdReg      <= '0;
            startPrevReg <= 1'b1;
            pausePrevReg <= 1'b1;
        end else begin
            startPrevReg <= SC_GAMECTRL_startButton_InLow;
            pausePrevReg <= SC_GAMECTRL_pauseButton_InLow;
            case (stateReg)
                IDLE, GAMEOVER, WIN: begin
                    if (startPress) stateReg <= START;
                end
                START: begin
                    livesReg <= LIFE_W'(LIVES_INIT);
                    levelReg <= '0;
                    maskReg  <= '0;
                    stateReg <= PLAY;
                end
                PLAY: begin
                    // Collision outranks a house event, which outranks pause.
                    if (!SC_GAMECTRL_Collision_InLow ||
                        (!SC_GAMECTRL_HouseValid_InLow && houseBad)) begin
                        livesReg <= livesReg - LIFE_W'(1);
                        holdReg  <= HOLD_W'(DEATH_HOLD - 1);
                        stateReg <= LOSELIFE;
                    end else if (!SC_GAMECTRL_HouseValid_InLow) begin
                        maskReg  <= maskReg | houseOneHot;
                        stateReg <= HOUSE;
                    end else if (pausePress) begin
                        stateReg <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (pausePress) stateReg <= PLAY;
                end
                LOSELIFE: begin
                    if (holdReg == '0) begin
                        stateReg <= (livesReg == '0) ? GAMEOVER : PLAY;
                    end else begin
                        holdReg <= holdReg - HOLD_W'(1);
                    end
                end
                HOUSE: begin
                    if (!(&maskReg)) begin
                        stateReg <= PLAY;
                    end else if (levelReg == LEVEL_W'(LEVELS - 1)) begin
                        stateReg <= WIN;
                    end else begin
                        levelReg <= levelReg + LEVEL_W'(1);
                        maskReg  <= '0;
                        holdReg  <= HOLD_W'(LEVEL_HOLD - 1);
                        stateReg <= LEVELUP;
                    end
                end
                LEVELUP: begin
                    if (holdReg == '0) begin
                        stateReg <= PLAY;
                    end else begin
                        holdReg <= holdReg - HOLD_W'(1);
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // Moore output decode; first/final hold cycles are recognised by the hold value.
    assign SC_GAMECTRL_StartGame_OutLow = ~(stateReg == START);
    assign SC_GAMECTRL_LoadLevel_OutLow = ~((stateReg == LEVELUP) && (holdReg == HOLD_W'(LEVEL_HOLD - 1)));
    assign SC_GAMECTRL_LifeLost_OutLow  = ~((stateReg == LOSELIFE) && (holdReg == HOLD_W'(DEATH_HOLD - 1)));
    assign SC_GAMECTRL_ResetFrog_OutLow = ~((stateReg == START) || (stateReg == HOUSE) ||
                                            ((stateReg == LOSELIFE) && (holdReg == '0) && (livesReg != '0)) ||
                                            ((stateReg == LEVELUP) && (holdReg == '0)));
    assign SC_GAMECTRL_Freeze_OutLow    = (stateReg == PLAY);
    assign SC_GAMECTRL_Win_OutHigh      = (stateReg == WIN);
    assign SC_GAMECTRL_Lose_OutHigh     = (stateReg == GAMEOVER);
    assign SC_GAMECTRL_Lives_OutBUS     = livesReg;
    assign SC_GAMECTRL_Level_OutBUS     = levelReg;
    assign SC_GAMECTRL_HouseMask_OutBUS = maskReg;
    assign SC_GAMECTRL_State_OutBUS     = stateReg;

endmodule
